demux_bit_collector: RTL and testbench
======================================

# demux_bit_collector

Downstream consumer of the 1:8 demultiplexer. Each accepted beat takes the demultiplexer's 8-bit output `y` and its select `s`, captures bit `y[s]` into position `s` of an assembly register, and tracks which positions are filled. Once all eight positions are filled, it presents the assembled byte on a valid/ready output port. It turns the demux's one-hot bit routing back into a parallel word and flags malformed traffic.

## Interface
Parameters:
- `DUP_POLICY`, default 0. Behaviour when a position is written twice before the word completes: 0 = overwrite with the new bit; 1 = keep the first bit.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `y`  in  8  demultiplexer output vector.
- `s`  in  3  demultiplexer select, the same value that drives the demux.
- `in_valid`  in  1  a beat (`y`, `s`) is presented.
- `in_ready`  out  1  collector can accept a beat.
- `clear`  in  1  synchronous abort of a partially assembled word.
- `out_data`  out  8  assembled byte; bit k came from a beat with `s`=k.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `dup_err`  out  1  one-cycle pulse: an accepted beat hit an already-filled position.
- `stray_err`  out  1  one-cycle pulse: an accepted beat had a 1 on any `y` bit other than `y[s]`.

## Operation
- State machine with two states. COLLECT is the reset state. PRESENT holds a completed word.
- Accept condition: `in_valid && in_ready`. `in_ready` is combinational and equals (state == COLLECT). It does not depend on `in_valid`.
- On accept in COLLECT:
  - `asm[s]` is written with `y[s]` and `mask[s]` is set.
  - If `mask[s]` was already set, `dup_err` pulses. The bit is then written only when `DUP_POLICY`=0.
  - `stray_err` pulses when `(y & ~(8'b1 << s)) != 0`. The captured bit is still `y[s]`.
  - When the updated mask equals 8'hFF: `out_data` is loaded with the updated `asm`, the mask clears, and the state moves to PRESENT.
- In PRESENT: when `out_valid && out_ready`, the state returns to COLLECT. `out_data` holds its value until the next word loads.
- `clear`:
  - In COLLECT, it zeroes `mask` and `asm`. If a beat is accepted in the same cycle, `clear` wins and the beat is discarded, with no error pulses.
  - In PRESENT, `clear` is ignored.
- Completion order is free: any permutation of the eight `s` values completes a word.
- Reset mid-word discards the partial word. Reset while in PRESENT drops the pending byte.

## Timing
- Reset values: state = COLLECT, `mask` = 0, `asm` = 0, `out_data` = 8'h00, `out_valid` = 0, `in_ready` = 1, `dup_err` = 0, `stray_err` = 0. `out_parity` = 0 when configured.
- `rst` has priority over all other inputs.
- Error pulses are registered. They are high in the cycle after the accepting edge, for exactly one cycle.
- Latency: the final beat is accepted at edge N. `out_valid` is high from edge N onward, and `in_ready` is low in that same cycle.
- Output handshake completes at edge M. `out_valid` drops and `in_ready` rises after M. A new beat can be accepted at edge M+1.
- Throughput: at most one word per 9 cycles with `out_ready` tied high (8 beats + 1 present cycle).
- `out_data` and `out_valid` are stable while `out_valid && !out_ready`.
- `y` and `s` are sampled only on accept. Their values with `in_valid` low are don't-care.

## Configuration
- `DEMUX_COLLECT_PARITY_EN`
  - Defined: adds output `out_parity` (1 bit), registered alongside `out_data`. It equals the XOR of the eight bits being loaded, giving even parity over the 9 bits. It holds with `out_data` and resets to 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Ordered fill: beats `s`=0..7 with `y` = one-hot of pattern 8'hA5 -> `out_valid` in the cycle after the 8th accept, `out_data`=8'hA5, no error pulses. With the macro, `out_parity`=0.
- Shuffled order with backpressure: `s` sequence 7,2,5,0,3,6,1,4 forming 8'h3C, with `out_ready` low for 4 cycles -> `out_data` held at 8'h3C, `in_ready`=0 throughout. After `out_ready`, the next word accepts one cycle later.
- Duplicate: `s`=3 written with 1 then 0, other positions 0, run with `DUP_POLICY`=0 and again with 1 -> one `dup_err` pulse in each case. `out_data`=8'h00 (policy 0), 8'h08 (policy 1).
- Stray bit: beat `s`=1 with `y`=8'b0000_0110 -> `stray_err` pulses, position 1 captures 1. Completed word has bit2 taken only from the `s`=2 beat.
- Clear and reset: 5 beats, then `clear` together with a valid beat -> no capture, no errors. A following full 8-beat word yields the correct byte. Asserting `rst` in PRESENT -> `out_valid`=0 and `out_data`=8'h00 next cycle.

Source files
------------

// File: rtl/demux_bit_collector.sv
// Reassembles one-hot routed bits from a 1:8 demultiplexer into a byte with a valid/ready output.
// Optional macro DEMUX_COLLECT_PARITY_EN adds an even-parity output registered with out_data.
module demux_bit_collector #(
    parameter int DUP_POLICY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] y,
    input  logic [2:0] s,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dup_err,
    output logic       stray_err
`ifdef DEMUX_COLLECT_PARITY_EN
    ,
    output logic       out_parity
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] asm_q, asm_d;
    logic [7:0] out_data_q, out_data_d;
    logic       dup_q, dup_d;
    logic       stray_q, stray_d;
    logic [7:0] sel_onehot;
    logic       accept;
`ifdef DEMUX_COLLECT_PARITY_EN
    logic       parity_q, parity_d;
`endif

    assign sel_onehot = 8'b1 << s;
    assign in_ready   = (state_q == COLLECT);
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        asm_d      = asm_q;
        out_data_d = out_data_q;
        dup_d      = 1'b0;
        stray_d    = 1'b0;
`ifdef DEMUX_COLLECT_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q == COLLECT) begin
            // clear wins over a beat arriving in the same cycle
            if (clear) begin
                mask_d = 8'h00;
                asm_d  = 8'h00;
            end else if (accept) begin
                dup_d   = mask_q[s];
                stray_d = |(y & ~sel_onehot);
                if (!mask_q[s] || (DUP_POLICY == 0)) begin
                    asm_d[s] = y[s];
                end
                mask_d = mask_q | sel_onehot;
                if (&mask_d) begin
                    out_data_d = asm_d;
`ifdef DEMUX_COLLECT_PARITY_EN
                    parity_d   = ^asm_d;
`endif
                    mask_d     = 8'h00;
                    state_d    = PRESENT;
                end
            end
        end else begin
            if (out_ready) begin
                state_d = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            mask_q     <= 8'h00;
            asm_q      <= 8'h00;
            out_data_q <= 8'h00;
            dup_q      <= 1'b0;
            stray_q    <= 1'b0;
`ifdef DEMUX_COLLECT_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            asm_q      <= asm_d;
            out_data_q <= out_data_d;
            dup_q      <= dup_d;
            stray_q    <= stray_d;
`ifdef DEMUX_COLLECT_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == PRESENT);
    assign dup_err   = dup_q;
    assign stray_err = stray_q;
`ifdef DEMUX_COLLECT_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_demux_bit_collector.sv
// Bench for demux_bit_collector: two instances (DUP_POLICY 0 and 1) share stimulus and a word-level model.
module tb_demux_bit_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [2:0] s_in;

    logic       in_ready_w  [2];
    logic       out_valid_w [2];
    logic [7:0] out_data_w  [2];
    logic       dup_w       [2];
    logic       stray_w     [2];
`ifdef DEMUX_COLLECT_PARITY_EN
    logic       parity_w    [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_bit_collector #(.DUP_POLICY(0)) dut0 (
        .clk(clk), .rst(rst), .y(y), .s(s_in), .in_valid(in_valid),
        .in_ready(in_ready_w[0]), .clear(clear), .out_data(out_data_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .dup_err(dup_w[0]), .stray_err(stray_w[0])
`ifdef DEMUX_COLLECT_PARITY_EN
        , .out_parity(parity_w[0])
`endif
    );

    demux_bit_collector #(.DUP_POLICY(1)) dut1 (
        .clk(clk), .rst(rst), .y(y), .s(s_in), .in_valid(in_valid),
        .in_ready(in_ready_w[1]), .clear(clear), .out_data(out_data_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .dup_err(dup_w[1]), .stray_err(stray_w[1])
`ifdef DEMUX_COLLECT_PARITY_EN
        , .out_parity(parity_w[1])
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word-level model: per position, the first and last bit written in the current word.
    bit         filled [8];
    logic [7:0] first_b, last_b;
    bit         pending;
    logic [7:0] exp_out [2];
    bit         exp_dup, exp_stray;

    initial begin
        pending    = 1'b0;
        exp_out[0] = 8'h00;
        exp_out[1] = 8'h00;
        first_b    = 8'h00;
        last_b     = 8'h00;
        exp_dup    = 1'b0;
        exp_stray  = 1'b0;
        foreach (filled[i]) filled[i] = 1'b0;
    end

    always @(posedge clk) begin
        int nfill;
        exp_dup   = 1'b0;
        exp_stray = 1'b0;
        if (rst) begin
            foreach (filled[i]) filled[i] = 1'b0;
            pending    = 1'b0;
            exp_out[0] = 8'h00;
            exp_out[1] = 8'h00;
        end else if (!pending) begin
            if (clear) begin
                foreach (filled[i]) filled[i] = 1'b0;
            end else if (in_valid) begin
                if (filled[s_in]) exp_dup = 1'b1;
                else first_b[s_in] = y[s_in];
                last_b[s_in]   = y[s_in];
                filled[s_in]   = 1'b1;
                for (int k = 0; k < 8; k++)
                    if (k != int'(s_in) && y[k]) exp_stray = 1'b1;
                nfill = 0;
                foreach (filled[i]) nfill += int'(filled[i]);
                if (nfill == 8) begin
                    exp_out[0] = last_b;
                    exp_out[1] = first_b;
                    foreach (filled[i]) filled[i] = 1'b0;
                    pending = 1'b1;
                end
            end
        end else if (out_ready) begin
            pending = 1'b0;
        end
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("p%0d in_ready", p),  8'(in_ready_w[p]),  8'(!pending));
            check($sformatf("p%0d out_valid", p), 8'(out_valid_w[p]), 8'(pending));
            check($sformatf("p%0d out_data", p),  out_data_w[p],      exp_out[p]);
            check($sformatf("p%0d dup_err", p),   8'(dup_w[p]),       8'(exp_dup));
            check($sformatf("p%0d stray_err", p), 8'(stray_w[p]),     8'(exp_stray));
`ifdef DEMUX_COLLECT_PARITY_EN
            check($sformatf("p%0d out_parity", p), 8'(parity_w[p]),   8'(^exp_out[p]));
`endif
        end
    end

    task automatic beat(input logic [2:0] sv, input logic [7:0] yv);
        in_valid = 1'b1;
        s_in     = sv;
        y        = yv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fill_word(input logic [7:0] pat);
        for (int k = 0; k < 8; k++) beat(3'(k), pat & (8'b1 << k));
    endtask

    task automatic lit(input string name, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] e0, input logic [7:0] e1);
        check({name, " p0"}, a0, e0);
        check({name, " p1"}, a1, e1);
    endtask

    initial begin
        logic [2:0] order [8];
        order = '{3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4};
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; y = 8'h00; s_in = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lit("reset in_ready", 8'(in_ready_w[0]), 8'(in_ready_w[1]), 8'h01, 8'h01);
        lit("reset out_valid", 8'(out_valid_w[0]), 8'(out_valid_w[1]), 8'h00, 8'h00);
        lit("reset out_data", out_data_w[0], out_data_w[1], 8'h00, 8'h00);

        // ordered fill of A5
        fill_word(8'hA5);
        lit("A5 out_valid", 8'(out_valid_w[0]), 8'(out_valid_w[1]), 8'h01, 8'h01);
        lit("A5 in_ready", 8'(in_ready_w[0]), 8'(in_ready_w[1]), 8'h00, 8'h00);
        lit("A5 out_data", out_data_w[0], out_data_w[1], 8'hA5, 8'hA5);
`ifdef DEMUX_COLLECT_PARITY_EN
        lit("A5 parity", 8'(parity_w[0]), 8'(parity_w[1]), 8'h00, 8'h00);
`endif
        @(negedge clk);

        // shuffled order with 4 cycles of backpressure
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) beat(order[k], 8'h3C & (8'b1 << order[k]));
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; s_in = 3'd0; y = 8'h01;
            @(negedge clk);
            lit("3C held data", out_data_w[0], out_data_w[1], 8'h3C, 8'h3C);
            lit("3C held in_ready", 8'(in_ready_w[0]), 8'(in_ready_w[1]), 8'h00, 8'h00);
        end
        out_ready = 1'b1;
        @(negedge clk);
        lit("after handshake in_ready", 8'(in_ready_w[0]), 8'(in_ready_w[1]), 8'h01, 8'h01);
        lit("after handshake out_valid", 8'(out_valid_w[0]), 8'(out_valid_w[1]), 8'h00, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // duplicate on position 3
        beat(3'd3, 8'h08);
        beat(3'd3, 8'h00);
        lit("dup pulse", 8'(dup_w[0]), 8'(dup_w[1]), 8'h01, 8'h01);
        beat(3'd0, 8'h00); beat(3'd1, 8'h00); beat(3'd2, 8'h00);
        beat(3'd4, 8'h00); beat(3'd5, 8'h00); beat(3'd6, 8'h00); beat(3'd7, 8'h00);
        lit("dup policy data", out_data_w[0], out_data_w[1], 8'h00, 8'h08);
        @(negedge clk);

        // stray bit on s=1
        beat(3'd1, 8'h06);
        lit("stray pulse", 8'(stray_w[0]), 8'(stray_w[1]), 8'h01, 8'h01);
        beat(3'd0, 8'h00); beat(3'd2, 8'h00);
        for (int k = 3; k < 8; k++) beat(3'(k), 8'h00);
        lit("stray data", out_data_w[0], out_data_w[1], 8'h02, 8'h02);
        @(negedge clk);

        // clear colliding with a beat, then a full word, then reset in PRESENT
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) beat(3'(k), 8'h5A & (8'b1 << k));
        clear = 1'b1; in_valid = 1'b1; s_in = 3'd5; y = 8'hFF;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        lit("clear no dup", 8'(dup_w[0]), 8'(dup_w[1]), 8'h00, 8'h00);
        lit("clear no stray", 8'(stray_w[0]), 8'(stray_w[1]), 8'h00, 8'h00);
        fill_word(8'h5A);
        lit("5A out_data", out_data_w[0], out_data_w[1], 8'h5A, 8'h5A);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lit("rst PRESENT out_valid", 8'(out_valid_w[0]), 8'(out_valid_w[1]), 8'h00, 8'h00);
        lit("rst PRESENT out_data", out_data_w[0], out_data_w[1], 8'h00, 8'h00);
        lit("rst PRESENT in_ready", 8'(in_ready_w[0]), 8'(in_ready_w[1]), 8'h01, 8'h01);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
